// File: rtl/peripheral_wb_pkg.sv
// Shared definitions for the WishBone UART peripheral: receiver states, LCR
// bit positions and receive-word error bit positions.
package peripheral_wb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        PUSH      = 3'd5,
        WAIT_IDLE = 3'd6
    } rx_state_e;

    localparam int unsigned LCR_WLS_LO = 0;
    localparam int unsigned LCR_WLS_HI = 1;
    localparam int unsigned LCR_STB    = 2;
    localparam int unsigned LCR_PEN    = 3;
    localparam int unsigned LCR_EPS    = 4;
    localparam int unsigned LCR_SP     = 5;

    localparam int unsigned UART_RX_BRK = 2;
    localparam int unsigned UART_RX_PE  = 1;
    localparam int unsigned UART_RX_FE  = 0;

    // Data bits above the word length are zero, so XOR over all 8 bits is safe.
    function automatic logic rx_parity_expected(input logic [5:0] lcr, input logic [7:0] data);
        if (lcr[LCR_SP])
            return ~lcr[LCR_EPS];
        else if (lcr[LCR_EPS])
            return ^data;
        else
            return ~^data;
    endfunction

endpackage

// File: rtl/peripheral_uart_sync_wb.sv
// Multi-flop synchronizer for an asynchronous, idle-high serial input.
module peripheral_uart_sync_wb #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sync_q <= '1;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/peripheral_uart_receiver_wb.sv
// UART receiver: 16x oversampled deframing of srx_pad_i into one
// {data, break, parity_err, framing_err} word pushed per frame.
module peripheral_uart_receiver_wb
    import peripheral_wb_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH  = 11,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic                  srx_pad_i,
    input  logic [5:0]            lcr,
    input  logic                  rx_reset,
    output logic                  rf_push,
    output logic [FIFO_WIDTH-1:0] rf_data_in,
    output logic [2:0]            rstate
);

    rx_state_e             state_q, state_d;
    logic [3:0]            tick_q, tick_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            data_q, data_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_err_q, par_err_d;
    logic [FIFO_WIDTH-1:0] rf_data_q, rf_data_d;
    logic                  srx_s;
    logic                  mid;
    logic [2:0]            last_bit;
    logic                  stb_unused;

    peripheral_uart_sync_wb #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk),
        .rst_i(wb_rst_i),
        .d_i  (srx_pad_i),
        .q_o  (srx_s)
    );

    assign stb_unused = lcr[LCR_STB];
    assign mid        = enable && (tick_q == 4'd7);
    assign last_bit   = 3'd4 + {1'b0, lcr[LCR_WLS_HI:LCR_WLS_LO]};

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        rf_data_d = rf_data_q;

        unique case (state_q)
            IDLE: begin
                if (enable && !srx_s) begin
                    state_d   = START;
                    tick_d    = '0;
                    data_d    = '0;
                    par_bit_d = 1'b0;
                    par_err_d = 1'b0;
                end
            end
            // The tick counter free-runs through 15->0, so each later
            // mid-sample lands 16 ticks after the previous one.
            START: begin
                if (enable) begin
                    tick_d = tick_q + 4'd1;
                    if (mid) begin
                        if (srx_s) begin
                            state_d = IDLE;
                            tick_d  = '0;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (enable) begin
                    tick_d = tick_q + 4'd1;
                    if (mid) begin
                        data_d[bit_q] = srx_s;
                        if (bit_q == last_bit)
                            state_d = lcr[LCR_PEN] ? PARITY : STOP;
                        else
                            bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (enable) begin
                    tick_d = tick_q + 4'd1;
                    if (mid) begin
                        par_bit_d = srx_s;
                        par_err_d = (srx_s != rx_parity_expected(lcr, data_q));
                        state_d   = STOP;
                    end
                end
            end
            STOP: begin
                if (enable) begin
                    tick_d = tick_q + 4'd1;
                    if (mid) begin
                        rf_data_d              = '0;
                        rf_data_d[10:3]        = data_q;
                        rf_data_d[UART_RX_BRK] = (data_q == 8'd0) && !(lcr[LCR_PEN] && par_bit_q)
                                                 && !srx_s;
                        rf_data_d[UART_RX_PE]  = lcr[LCR_PEN] && par_err_q;
                        rf_data_d[UART_RX_FE]  = !srx_s;
                        state_d                = PUSH;
                    end
                end
            end
            PUSH: begin
                tick_d  = '0;
                state_d = rf_data_q[UART_RX_FE] ? WAIT_IDLE : IDLE;
            end
            WAIT_IDLE: begin
                if (srx_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i || rx_reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_push    = (state_q == PUSH) && !rx_reset;
    assign rf_data_in = rf_data_q;
    assign rstate     = state_q;

endmodule

// File: tb/tb_peripheral_uart_receiver_wb.sv
// Self-checking bench for peripheral_uart_receiver_wb: directed frames plus
// randomized frames checked against an arithmetic frame model.
module tb_peripheral_uart_receiver_wb;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        enable;
    logic        srx_pad_i;
    logic [5:0]  lcr;
    logic        rx_reset;
    logic        rf_push;
    logic [10:0] rf_data_in;
    logic [2:0]  rstate;

    int unsigned en_period = 1;
    int          n_checks  = 0;
    int          n_pass    = 0;
    logic [10:0] pushq[$];

    always #5 clk = ~clk;

    peripheral_uart_receiver_wb #(
        .FIFO_WIDTH (11),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (enable),
        .srx_pad_i (srx_pad_i),
        .lcr       (lcr),
        .rx_reset  (rx_reset),
        .rf_push   (rf_push),
        .rf_data_in(rf_data_in),
        .rstate    (rstate)
    );

    // 16x tick: one clk high out of every en_period clks.
    initial begin
        int unsigned cnt;
        cnt    = 0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= en_period) begin
                cnt    = 0;
                enable = 1'b1;
            end else begin
                enable = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rf_push)
            pushq.push_back(rf_data_in);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!enable);
        end
        #2;
    endtask

    task automatic send_bit(input logic b);
        srx_pad_i = b;
        tick(16);
    endtask

    task automatic send_frame(input logic [5:0] l, input logic [7:0] d,
                              input logic pb, input logic sb);
        int n;
        lcr = l;
        n   = 5 + int'(l[1:0]);
        send_bit(1'b0);
        for (int i = 0; i < n; i++)
            send_bit(d[i]);
        if (l[3])
            send_bit(pb);
        send_bit(sb);
        srx_pad_i = 1'b1;
        tick(3);
    endtask

    // Expected pushed word for a frame, derived from the framing rules.
    function automatic logic [10:0] model(input logic [5:0] l, input logic [7:0] d,
                                          input logic pb, input logic sb);
        int n, dv, ones, exp_par, pe, fe, brk;
        n    = 5 + int'(l[1:0]);
        dv   = int'(d) % (1 << n);
        ones = 0;
        for (int i = 0; i < n; i++)
            ones += (dv >> i) & 1;
        if (l[5])
            exp_par = l[4] ? 0 : 1;
        else if (l[4])
            exp_par = ones % 2;
        else
            exp_par = 1 - (ones % 2);
        pe  = (l[3] && (int'(pb) != exp_par)) ? 1 : 0;
        fe  = (sb == 1'b0) ? 1 : 0;
        brk = (dv == 0 && (!l[3] || pb == 1'b0) && sb == 1'b0) ? 1 : 0;
        return 11'(dv * 8 + brk * 4 + pe * 2 + fe);
    endfunction

    task automatic expect_one(input string tag, input logic [10:0] exp);
        chk({tag, "_count"}, pushq.size(), 1);
        if (pushq.size() > 0)
            chk({tag, "_word"}, pushq.pop_front(), exp);
        pushq.delete();
    endtask

    initial begin
        logic [5:0] l;
        logic [7:0] d;
        logic       pb, sb;

        wb_rst_i  = 1'b1;
        rx_reset  = 1'b0;
        srx_pad_i = 1'b1;
        lcr       = 6'b000011;
        repeat (3) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        @(negedge clk);
        chk("reset_rstate", rstate, 3'd0);
        chk("reset_push", rf_push, 1'b0);
        chk("reset_data", rf_data_in, 11'h000);
        tick(4);

        send_frame(6'b000011, 8'hA5, 1'b0, 1'b1);
        expect_one("8n1_a5", 11'h528);

        send_frame(6'b011010, 8'h35, 1'b1, 1'b1);
        expect_one("7e1_bad_par", 11'h1AA);
        send_frame(6'b011010, 8'h35, 1'b0, 1'b1);
        expect_one("7e1_good_par", 11'h1A8);

        lcr       = 6'b000011;
        srx_pad_i = 1'b0;
        tick(320);
        expect_one("break", 11'h005);
        srx_pad_i = 1'b1;
        tick(6);
        chk("break_idle", rstate, 3'd0);
        send_frame(6'b000011, 8'h3C, 1'b0, 1'b1);
        expect_one("after_break", 11'h1E0);

        srx_pad_i = 1'b0;
        tick(4);
        srx_pad_i = 1'b1;
        tick(8);
        chk("glitch_rstate", rstate, 3'd0);
        chk("glitch_nopush", pushq.size(), 0);
        tick(8);

        lcr = 6'b000011;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx_reset = 1'b1;
        @(posedge clk);
        #1 rx_reset = 1'b0;
        srx_pad_i = 1'b1;
        tick(200);
        chk("rxreset_nopush", pushq.size(), 0);
        chk("rxreset_rstate", rstate, 3'd0);
        pushq.delete();
        send_frame(6'b000011, 8'h81, 1'b0, 1'b1);
        expect_one("after_rxreset", 11'h408);

        for (int p = 1; p <= 4; p += 3) begin
            en_period = p;
            tick(2);
            send_frame(6'b111000, 8'h1F, 1'b1, 1'b1);
            expect_one("stick_par1", 11'h0FA);
            send_frame(6'b111000, 8'h1F, 1'b0, 1'b1);
            expect_one("stick_par0", 11'h0F8);
        end

        for (int k = 0; k < 40; k++) begin
            en_period = $urandom_range(1, 3);
            l  = 6'($urandom);
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                d  = 8'h00;
                pb = 1'b0;
                sb = 1'b0;
            end
            tick(2);
            send_frame(l, d, pb, sb);
            expect_one("random", model(l, d, pb, sb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
